// File: rtl/arm_lsu_pkg.sv
// Shared types and helpers for the ARM load/store unit.
package arm_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/arm_lsu_lane.sv
// Byte-lane datapath: alignment check, lane enables, store replication and
// load extract/extend. Purely combinational.
module arm_lsu_lane
    import arm_lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = lanes(DATA_W),
    localparam int OFF    = $clog2(NB)
) (
    input  size_t             i_req_size,
    input  logic [OFF-1:0]    i_req_off,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_legal,
    output logic [NB-1:0]     o_be,
    output logic [DATA_W-1:0] o_wdata,
    input  size_t             i_rsp_size,
    input  logic [OFF-1:0]    i_rsp_off,
    input  logic              i_rsp_signed,
    input  logic [DATA_W-1:0] i_rsp_rdata,
    output logic [DATA_W-1:0] o_rsp_data
);

    int                w_req_bytes;
    int                w_rsp_bytes;
    int                w_msb;
    logic [DATA_W-1:0] w_shift;
    logic              w_fill;

    always_comb begin
        w_req_bytes = 1 << i_req_size;
        o_legal     = (int'(i_req_size) <= OFF) &&
                      ((int'(i_req_off) & (w_req_bytes - 1)) == 0);
        o_be        = '0;
        o_wdata     = '0;
        // Lane i carries source byte (i mod size), i.e. the datum repeated.
        for (int i = 0; i < NB; i++) begin
            o_be[i]           = (i >= int'(i_req_off)) && (i < int'(i_req_off) + w_req_bytes);
            o_wdata[8*i +: 8] = i_req_wdata[8*(i & (w_req_bytes - 1)) +: 8];
        end
    end

    always_comb begin
        w_rsp_bytes = 1 << i_rsp_size;
        w_msb       = (w_rsp_bytes > NB) ? DATA_W - 1 : 8 * w_rsp_bytes - 1;
        w_shift     = i_rsp_rdata >> {i_rsp_off, 3'b000};
        w_fill      = i_rsp_signed & w_shift[w_msb];
        o_rsp_data  = '0;
        for (int i = 0; i < NB; i++) begin
            o_rsp_data[8*i +: 8] = (i < w_rsp_bytes) ? w_shift[8*i +: 8] : {8{w_fill}};
        end
    end

endmodule

// File: rtl/arm_lsu.sv
// Load/store unit: latches a core request, runs a valid/ready access to
// variable-latency memory with a timeout, and returns extended load data.
module arm_lsu
    import arm_lsu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    input  logic                  i_req_write,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_fault,
    output logic                  o_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W/8-1:0]   o_mem_be,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    input  logic                  i_mem_ready,
    output lsu_state_t            o_state
);

    localparam int NB    = lanes(DATA_W);
    localparam int OFF   = $clog2(NB);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    // Handshake: the core holds i_req_valid and its fields until o_done,
    // o_fault or o_err; memory sees o_mem_req with stable fields until it
    // answers i_mem_ready=1, which completes the access in that cycle.
    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_we;
    size_t             r_size;
    logic              r_signed;
    logic [OFF-1:0]    r_off;
    logic [ADDR_W-1:0] r_addr;
    logic [NB-1:0]     r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_latch;
    logic              w_access;
    logic              w_legal;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata_ext;

    arm_lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .i_req_size   (size_t'(i_req_size)),
        .i_req_off    (i_req_addr[OFF-1:0]),
        .i_req_wdata  (i_req_wdata),
        .o_legal      (w_legal),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .i_rsp_size   (r_size),
        .i_rsp_off    (r_off),
        .i_rsp_signed (r_signed),
        .i_rsp_rdata  (i_mem_rdata),
        .o_rsp_data   (w_rdata_ext)
    );

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        o_stall = 1'b0;
        o_done  = 1'b0;
        o_fault = 1'b0;
        o_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    if (w_legal) begin
                        w_latch = 1'b1;
                        o_stall = 1'b1;
                        w_next  = ACCESS;
                    end else begin
                        o_fault = 1'b1;
                    end
                end
            end
            ACCESS: begin
                o_stall = 1'b1;
                // A response in the timeout cycle still completes the access.
                if (i_mem_ready) begin
                    w_next = RESP;
                end else if (r_cnt == CNT_W'(MAX_WAIT)) begin
                    o_err  = 1'b1;
                    w_next = IDLE;
                end
            end
            RESP: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we     <= 1'b0;
            r_size   <= SZ_B;
            r_signed <= 1'b0;
            r_off    <= '0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
        end else if (w_latch) begin
            r_we     <= i_req_write;
            r_size   <= size_t'(i_req_size);
            r_signed <= i_req_signed;
            r_off    <= i_req_addr[OFF-1:0];
            r_addr   <= {i_req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ACCESS && w_next == ACCESS) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (r_state == ACCESS && i_mem_ready) begin
            r_rdata <= r_we ? '0 : w_rdata_ext;
        end
    end

    assign w_access    = (r_state == ACCESS);
    assign o_mem_req   = w_access;
    assign o_mem_we    = w_access & r_we;
    assign o_mem_addr  = w_access ? r_addr  : '0;
    assign o_mem_be    = w_access ? r_be    : '0;
    assign o_mem_wdata = w_access ? r_wdata : '0;
    assign o_rdata     = (r_state == RESP) ? r_rdata : '0;
    assign o_state     = r_state;

endmodule
